// File: rtl/scroll_msg_writer_if.sv
// Write port from the message composer into the renderer's character buffer.
// The master drives a beat, and the slave accepts it with wr_ready.
interface scroll_msg_writer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_addr;
  logic [5:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/scroll_msg_writer.sv
// Writes "AUDIO VOLUME IS NN" into the scroll renderer's character buffer.
// NN comes from the live volume level, using a one-subtract-per-cycle decimal split.
//
// state | meaning
// IDLE  | waiting for a pending request (reset, refresh or volume change)
// CONV  | splitting the snapshot into tens/units, one subtract per cycle
// WRITE | presenting slots 0..17 on the write port
// DONE  | one-cycle done pulse; records the snapshot as last written volume
module scroll_msg_writer #(
  parameter int         VOL_W      = 4,
  parameter logic [5:0] DIGIT_BASE = 6'd36,
  parameter logic [5:0] SPACE_CODE = 6'd63
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VOL_W-1:0]     vol,
  input  logic                 refresh,
  scroll_msg_writer_if.master  wr,
  output logic                 busy,
  output logic                 done
);

  localparam int SW = (VOL_W > 7) ? VOL_W : 7;

  typedef enum logic [1:0] {IDLE, CONV, WRITE, DONE} state_t;

  state_t      state;
  logic        pending;
  logic [6:0]  last_vol;
  logic [6:0]  snap;
  logic [6:0]  rem;
  logic [3:0]  tens;
  logic [SW-1:0] vol_ext;
  logic [6:0]  sat_vol;

  always_comb begin
    vol_ext = SW'(vol);
    sat_vol = (vol_ext > SW'(99)) ? 7'd99 : vol_ext[6:0];
  end

  function automatic logic [5:0] char_at(input logic [4:0] idx,
                                         input logic [3:0] t,
                                         input logic [5:0] u);
    case (idx)
      5'd0:    char_at = 6'd0;
      5'd1:    char_at = 6'd20;
      5'd2:    char_at = 6'd3;
      5'd3:    char_at = 6'd8;
      5'd4:    char_at = 6'd14;
      5'd5:    char_at = SPACE_CODE;
      5'd6:    char_at = 6'd21;
      5'd7:    char_at = 6'd14;
      5'd8:    char_at = 6'd11;
      5'd9:    char_at = 6'd20;
      5'd10:   char_at = 6'd12;
      5'd11:   char_at = 6'd4;
      5'd12:   char_at = SPACE_CODE;
      5'd13:   char_at = 6'd8;
      5'd14:   char_at = 6'd18;
      5'd15:   char_at = SPACE_CODE;
      5'd16:   char_at = DIGIT_BASE + {2'b00, t};
      5'd17:   char_at = DIGIT_BASE + u;
      default: char_at = SPACE_CODE;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= 1'b1;
      last_vol    <= 7'd0;
      snap        <= 7'd0;
      rem         <= 7'd0;
      tens        <= 4'd0;
      wr.wr_valid <= 1'b0;
      wr.wr_addr  <= 5'd0;
      wr.wr_data  <= 6'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      // Requests seen during a run collapse into a single rerun.
      if (state != IDLE && (refresh || sat_vol != snap))
        pending <= 1'b1;

      case (state)
        IDLE: begin
          if (pending) begin
            snap    <= sat_vol;
            rem     <= sat_vol;
            tens    <= 4'd0;
            pending <= refresh;
            busy    <= 1'b1;
            state   <= CONV;
          end else if (refresh || sat_vol != last_vol) begin
            pending <= 1'b1;
          end
        end
        CONV: begin
          if (rem >= 7'd10) begin
            rem  <= rem - 7'd10;
            tens <= tens + 4'd1;
          end else begin
            wr.wr_valid <= 1'b1;
            wr.wr_addr  <= 5'd0;
            wr.wr_data  <= char_at(5'd0, tens, rem[5:0]);
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (wr.wr_ready) begin
            if (wr.wr_addr == 5'd17) begin
              wr.wr_valid <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              wr.wr_addr <= wr.wr_addr + 5'd1;
              wr.wr_data <= char_at(wr.wr_addr + 5'd1, tens, rem[5:0]);
            end
          end
        end
        DONE: begin
          last_vol <= snap;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scroll_msg_writer.sv
// Directed bench for scroll_msg_writer: a message-level scoreboard checks every
// accepted beat, the done pulse and stall stability, plus literal spot checks.
module tb_scroll_msg_writer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] vol = 4'd0;
  logic       refresh = 1'b0;
  logic       busy, done;

  scroll_msg_writer_if wif();

  scroll_msg_writer #(.VOL_W(4), .DIGIT_BASE(6'd36), .SPACE_CODE(6'd63)) dut (
    .clk(clk), .rst(rst), .vol(vol), .refresh(refresh),
    .wr(wif.master), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int tmpl [16] = '{0, 20, 3, 8, 14, 63, 21, 14, 11, 20, 12, 4, 63, 8, 18, 63};
  int lit0 [18] = '{0, 20, 3, 8, 14, 63, 21, 14, 11, 20, 12, 4, 63, 8, 18, 63, 36, 36};
  logic rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  int   exp_q[$];
  int   units_q[$];
  int   cur_val = -1;
  int   beat = 0;
  int   beats_total = 0;
  int   done_cnt = 0;
  bit   exp_done = 1'b0;
  bit   stall = 1'b0;
  logic [4:0] s_addr;
  logic [5:0] s_data;
  logic [5:0] buf_mem [18];
  int   rdy_mode = 0;
  int   ph = 0;

  // Expected character for slot i of the message showing volume v.
  function automatic int msg_char(int v, int i);
    int s;
    s = (v > 99) ? 99 : v;
    if (i < 16) return tmpl[i];
    if (i == 16) return 36 + s / 10;
    return 36 + s % 10;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      beat = 0;
      exp_done = 1'b0;
      stall = 1'b0;
    end else begin
      check("done_pulse", done, exp_done);
      if (done) done_cnt++;
      exp_done = 1'b0;
      check("valid_implies_busy", wif.wr_valid & ~busy, 1'b0);
      if (stall) begin
        check("stall_valid", wif.wr_valid, 1'b1);
        check("stall_addr", wif.wr_addr, s_addr);
        check("stall_data", wif.wr_data, s_data);
      end
      stall  = wif.wr_valid && !wif.wr_ready;
      s_addr = wif.wr_addr;
      s_data = wif.wr_data;
      if (wif.wr_valid && wif.wr_ready) begin
        beats_total++;
        if (beat == 0) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_run: run started with no run expected");
            cur_val = -1;
          end else begin
            cur_val = exp_q.pop_front();
          end
        end
        check("beat_addr", wif.wr_addr, beat);
        if (cur_val >= 0) check("beat_data", wif.wr_data, msg_char(cur_val, beat));
        if (wif.wr_addr < 5'd18) buf_mem[wif.wr_addr] = wif.wr_data;
        if (beat == 17) begin
          units_q.push_back(int'(wif.wr_data));
          exp_done = 1'b1;
          beat = 0;
        end else begin
          beat++;
        end
      end
    end
  end

  initial begin
    wif.wr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) wif.wr_ready = 1'b1;
      else begin
        wif.wr_ready = rdy_pat[ph];
        ph = (ph + 1) % 4;
      end
    end
  end

  task automatic wait_dones(int target, int budget, string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt >= target) break;
    end
    vectors++;
    if (done_cnt < target) begin
      miscompares++;
      $display("FAIL %s_timeout: done count %0d expected %0d", name, done_cnt, target);
    end
  endtask

  task automatic wait_beat(int b, int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (beat >= b) break;
    end
    vectors++;
    if (beat < b) begin
      miscompares++;
      $display("FAIL wait_beat_timeout: beat %0d expected %0d", beat, b);
    end
  endtask

  task automatic pulse_refresh();
    @(posedge clk); #1 refresh = 1'b1;
    @(posedge clk); #1 refresh = 1'b0;
  endtask

  task automatic settle(int n, int exp_dones);
    repeat (n) @(posedge clk);
    #1;
    check("idle_busy", busy, 1'b0);
    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_cnt, exp_dones);
  endtask

  initial begin
    int lat;
    int b0;

    // Reset values and the automatic first write with vol=0.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", wif.wr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr", wif.wr_addr, 5'd0);
    check("rst_data", wif.wr_data, 6'd0);
    exp_q.push_back(0);
    rst = 1'b0;
    wait_dones(1, 100, "boot");
    settle(20, 1);
    for (int i = 0; i < 18; i++) check("boot_literal", buf_mem[i], lit0[i]);

    // Volume change to 13, then refresh latency.
    vol = 4'd13;
    exp_q.push_back(13);
    wait_dones(2, 100, "vol13");
    settle(5, 2);
    exp_q.push_back(13);
    @(posedge clk); #1 refresh = 1'b1;
    @(posedge clk); #1 refresh = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) check("conv_busy", busy, 1'b1);
      if (wif.wr_valid) begin
        lat = c;
        break;
      end
    end
    check("first_beat_latency", lat, 3);
    wait_dones(3, 100, "refresh13");
    settle(5, 3);
    check("slot16_13", buf_mem[16], 6'd37);
    check("slot17_13", buf_mem[17], 6'd39);

    // Stalling wr_ready pattern 1,0,0,1.
    b0 = beats_total;
    rdy_mode = 1;
    ph = 0;
    exp_q.push_back(13);
    pulse_refresh();
    wait_dones(4, 300, "stall");
    rdy_mode = 0;
    settle(5, 4);
    check("stall_beats", beats_total - b0, 18);

    // Volume 5 -> 9 during beat 7.
    vol = 4'd5;
    exp_q.push_back(5);
    wait_dones(5, 100, "vol5");
    settle(5, 5);
    units_q.delete();
    exp_q.push_back(5);
    exp_q.push_back(9);
    pulse_refresh();
    wait_beat(7, 100);
    vol = 4'd9;
    wait_dones(7, 300, "vol_mid");
    settle(10, 7);
    check("units_runs", units_q.size(), 2);
    if (units_q.size() == 2) begin
      check("units_first", units_q[0], 41);
      check("units_rerun", units_q[1], 45);
    end

    // Three refreshes during one run collapse into one rerun.
    exp_q.push_back(9);
    exp_q.push_back(9);
    pulse_refresh();
    wait_beat(2, 100);
    pulse_refresh();
    wait_beat(6, 100);
    pulse_refresh();
    wait_beat(12, 100);
    pulse_refresh();
    wait_dones(9, 300, "multi_refresh");
    settle(40, 9);

    // Refresh landing in the DONE cycle.
    exp_q.push_back(9);
    exp_q.push_back(9);
    pulse_refresh();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    check("done_seen", done, 1'b1);
    refresh = 1'b1;
    @(posedge clk); #1 refresh = 1'b0;
    wait_dones(11, 300, "refresh_in_done");
    settle(40, 11);

    // Reset at beat 10, then a full restart from slot 0.
    exp_q.push_back(9);
    pulse_refresh();
    wait_beat(10, 100);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", wif.wr_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    rst = 1'b0;
    exp_q.push_back(9);
    wait_dones(12, 100, "restart");
    settle(20, 12);
    check("restart_slot17", buf_mem[17], 6'd45);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
